// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the byte-serial data-memory arbiter: RV32I load/store
// size codes, FSM states, port identifiers and the access-size decode.
package dmem_arbiter_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_XFER  = 2'd1,
      ST_RTAIL = 2'd2,
      ST_DONE  = 2'd3
   } dmem_state_t;

   typedef enum logic {
      PORT_CORE = 1'b0,
      PORT_DBG  = 1'b1
   } dmem_port_t;

   // Index of the last byte of an access: 0 for byte, 1 for half, 3 for word.
   // The reserved codes (011/110/111) fall through to a full word.
   function automatic logic [1:0] last_byte_idx(input logic [2:0] funct3);
      case (funct3[1:0])
         2'b00:   last_byte_idx = 2'd0;
         2'b01:   last_byte_idx = 2'd1;
         default: last_byte_idx = 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/dmem_arbiter_load_ext.sv
// Load data extension: turns the assembled little-endian raw word into the
// architectural load result (sign/zero extension by funct3).
module load_ext
   import dmem_arbiter_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [31:0] raw,
   output logic [31:0] ext
);

   // Extend from bit 7 / bit 15 for signed loads, clear upper bits for unsigned.
   always_comb begin
      ext = raw;
      case (funct3)
         F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
         F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
         F3_BU:   ext = {24'h000000, raw[7:0]};
         F3_HU:   ext = {16'h0000, raw[15:0]};
         default: ext = raw;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Byte-serial data-memory arbiter between the pipeline MEM stage (core port)
// and the debug/program-loader port (dbg port).
//
//  state    | meaning
//  ---------+-----------------------------------------------------------------
//  ST_IDLE  | no access in flight; arbitrate and latch the winning request
//  ST_XFER  | one memory byte per cycle, k = 0..N-1; loads capture byte k-1
//  ST_RTAIL | load only: capture the last byte returned by the memory
//  ST_DONE  | one-cycle done pulse (and load data) on the granted port
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int AW           = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enable,
   input  logic          core_req,
   input  logic          core_we,
   input  logic [2:0]    core_funct3,
   input  logic [AW-1:0] core_addr,
   input  logic [31:0]   core_wdata,
   output logic [31:0]   core_rdata,
   output logic          core_done,
   output logic          core_stall,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [2:0]    dbg_funct3,
   input  logic [AW-1:0] dbg_addr,
   input  logic [31:0]   dbg_wdata,
   output logic [31:0]   dbg_rdata,
   output logic          dbg_done,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [7:0]    mem_wdata,
   input  logic [7:0]    mem_rdata
);

   localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   dmem_state_t   state_q, state_d;
   dmem_port_t    port_q, port_d;
   logic          we_q, we_d;
   logic [2:0]    f3_q, f3_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [SW-1:0] starve_q, starve_d;
   logic [31:0]   raw_q, raw_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          done_q, done_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic          mem_we_q, mem_we_d;
   logic [7:0]    mem_wdata_q, mem_wdata_d;

   logic          active;
   logic          starve_hit;
   logic          grant_dbg;
   logic          grant_any;
   logic          g_we;
   logic [2:0]    g_f3;
   logic [AW-1:0] g_addr;
   logic [31:0]   g_wdata;
   logic [1:0]    last_idx;
   logic [1:0]    nxt_idx;
   logic [1:0]    cap_idx;
   logic [31:0]   raw_cap;
   logic [31:0]   ext_data;

   // Core has priority unless the debug port has been passed over
   // STARVE_LIMIT times in a row; a lone dbg request always wins.
   assign starve_hit = (starve_q == SW'(STARVE_LIMIT));
   assign grant_dbg  = dbg_req & (starve_hit | ~core_req);
   assign grant_any  = core_req | dbg_req;
   assign g_we       = grant_dbg ? dbg_we      : core_we;
   assign g_f3       = grant_dbg ? dbg_funct3  : core_funct3;
   assign g_addr     = grant_dbg ? dbg_addr    : core_addr;
   assign g_wdata    = grant_dbg ? dbg_wdata   : core_wdata;

   assign last_idx = last_byte_idx(f3_q);
   assign nxt_idx  = cnt_q + 2'd1;
   // Read data lags the address by one cycle, so XFER captures the previous
   // byte and RTAIL captures the final one.
   assign cap_idx  = (state_q == ST_RTAIL) ? cnt_q : (cnt_q - 2'd1);

   // Merge the byte just returned by the memory into the raw load word.
   always_comb begin
      raw_cap = raw_q;
      raw_cap[{cap_idx, 3'b000} +: 8] = mem_rdata;
   end

   load_ext u_load_ext (
      .funct3 (f3_q),
      .raw    (raw_cap),
      .ext    (ext_data)
   );

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d     = state_q;
      port_d      = port_q;
      we_d        = we_q;
      f3_d        = f3_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      starve_d    = starve_q;
      raw_d       = raw_q;
      rdata_d     = '0;
      done_d      = 1'b0;
      mem_addr_d  = '0;
      mem_we_d    = 1'b0;
      mem_wdata_d = 8'h00;

      if (!dbg_req) begin
         starve_d = '0;
      end

      case (state_q)
         ST_IDLE: begin
            if (grant_any) begin
               port_d      = grant_dbg ? PORT_DBG : PORT_CORE;
               we_d        = g_we;
               f3_d        = g_f3;
               addr_d      = g_addr;
               wdata_d     = g_wdata;
               cnt_d       = 2'd0;
               raw_d       = '0;
               state_d     = ST_XFER;
               mem_addr_d  = g_addr;
               mem_we_d    = g_we;
               mem_wdata_d = g_we ? g_wdata[7:0] : 8'h00;
               if (grant_dbg) begin
                  starve_d = '0;
               end else if (dbg_req) begin
                  starve_d = starve_q + SW'(1);
               end
            end
         end

         ST_XFER: begin
            if (!we_q && (cnt_q != 2'd0)) begin
               raw_d = raw_cap;
            end
            if (cnt_q == last_idx) begin
               if (we_q) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_RTAIL;
               end
            end else begin
               cnt_d       = nxt_idx;
               mem_addr_d  = addr_q + AW'(nxt_idx);
               mem_we_d    = we_q;
               mem_wdata_d = we_q ? wdata_q[{nxt_idx, 3'b000} +: 8] : 8'h00;
            end
         end

         ST_RTAIL: begin
            raw_d   = raw_cap;
            rdata_d = ext_data;
            done_d  = 1'b1;
            state_d = ST_DONE;
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM and registered outputs; enable=0 freezes everything in place.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         port_q      <= PORT_CORE;
         we_q        <= 1'b0;
         f3_q        <= 3'b000;
         addr_q      <= '0;
         wdata_q     <= '0;
         cnt_q       <= 2'd0;
         starve_q    <= '0;
         raw_q       <= '0;
         rdata_q     <= '0;
         done_q      <= 1'b0;
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= 8'h00;
      end else if (enable) begin
         state_q     <= state_d;
         port_q      <= port_d;
         we_q        <= we_d;
         f3_q        <= f3_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
         starve_q    <= starve_d;
         raw_q       <= raw_d;
         rdata_q     <= rdata_d;
         done_q      <= done_d;
         mem_addr_q  <= mem_addr_d;
         mem_we_q    <= mem_we_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   // A frozen or resetting arbiter must not write memory or signal completion,
   // even for the byte already presented on the bus.
   assign active     = enable & rst;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_we     = mem_we_q & active;
   assign core_done  = done_q & active & (port_q == PORT_CORE);
   assign dbg_done   = done_q & active & (port_q == PORT_DBG);
   assign core_rdata = core_done ? rdata_q : 32'h0;
   assign dbg_rdata  = dbg_done  ? rdata_q : 32'h0;
   assign core_stall = core_req & ~core_done;

endmodule
